// File: rtl/binary_decoder_seq.sv
// Timed 3-to-8 decoder: queues 3-bit codes in a small FIFO and
// drives each one as a one-hot line for HOLD enabled cycles.
module binary_decoder_seq #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     EN,
  input  logic [2:0]               Y,
  input  logic                     Valid,
  output logic                     Ready,
  output logic [7:0]               Out,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [2:0]    head;
  logic [2:0]    cur;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          empty;

  assign Ready = (Count != FULL);
  assign push  = Valid & Ready;
  assign empty = (Count == '0);
  assign head  = mem[rp];
  assign Busy  = (state == S_HOLD);

  // A pop happens whenever the output stage wants a new code
  always_comb begin
    pop = 1'b0;
    if (EN && !empty)
      pop = (state == S_IDLE) || (cnt == '0);
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wp] <= Y;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wp    <= '0;
      rp    <= '0;
      Count <= '0;
      Ovf   <= 1'b0;
    end else begin
      if (push)
        wp <= wp + AW'(1);
      if (pop)
        rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   Count <= Count + (AW+1)'(1);
        2'b01:   Count <= Count - (AW+1)'(1);
        default: Count <= Count;
      endcase
      if (Valid && !Ready)
        Ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      cur   <= '0;
      Out   <= '0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            cur   <= head;
            Out   <= 8'b1 << head;
            cnt   <= CNT_LOAD;
            state <= S_HOLD;
          end else begin
            Out <= '0;
          end
        end
        S_HOLD: begin
          if (!EN) begin
            Out <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            Out <= 8'b1 << cur;
          end else begin
            Done <= 1'b1;
            if (pop) begin
              cur <= head;
              Out <= 8'b1 << head;
              cnt <= CNT_LOAD;
            end else begin
              Out   <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_decoder_seq.sv
// Directed bench for binary_decoder_seq: scoreboard of expected
// one-hot codes plus cycle-level checks on status outputs.
module tb_binary_decoder_seq;

  localparam int HOLD = 4;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       EN, Valid;
  logic [2:0] Y;
  logic       Ready, Busy, Done, Ovf;
  logic [7:0] Out;
  logic [2:0] Count;

  logic       ENb, Validb;
  logic [2:0] Yb;
  logic       Readyb, Busyb, Doneb, Ovfb;
  logic [7:0] Outb;
  logic [2:0] Countb;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] cur;
  int         len;

  always #5 CLK = ~CLK;

  binary_decoder_seq #(.HOLD(HOLD), .DEPTH(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .Y(Y), .Valid(Valid),
    .Ready(Ready), .Out(Out), .Busy(Busy), .Done(Done),
    .Count(Count), .Ovf(Ovf)
  );

  binary_decoder_seq #(.HOLD(1), .DEPTH(4)) dutb (
    .CLK(CLK), .RST_n(RST_n), .EN(ENb), .Y(Yb), .Valid(Validb),
    .Ready(Readyb), .Out(Outb), .Busy(Busyb), .Done(Doneb),
    .Count(Countb), .Ovf(Ovfb)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: one popped entry per new code; runs must last HOLD
  task automatic mon();
    if (Done) begin
      chk("done_len", len, HOLD);
      len = 0;
    end
    if (Out != 8'h00) begin
      if (len == 0) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {24'h0, Out}, 32'h0);
        end else begin
          chk("out_code", {24'h0, Out}, {24'h0, q.pop_front()});
        end
        cur = Out;
        len = 1;
      end else begin
        chk("out_hold", {24'h0, Out}, {24'h0, cur});
        len++;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    mon();
  endtask

  task automatic put(input logic [2:0] y, input bit accept);
    Valid = 1'b1;
    Y     = y;
    if (accept)
      q.push_back(8'b1 << y);
  endtask

  initial begin
    RST_n = 1'b0; EN = 1'b0; Valid = 1'b0; Y = '0;
    ENb = 1'b0; Validb = 1'b0; Yb = '0;
    len = 0; cur = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out", Out, 0);
    chk("rst_ready", Ready, 1);
    chk("rst_count", Count, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_ovf", Ovf, 0);
    RST_n = 1'b1;
    tick();

    // 1: single code
    EN = 1'b1;
    put(3'd5, 1);
    tick();
    Valid = 1'b0;
    chk("t1_count1", Count, 1);
    chk("t1_out0", Out, 0);
    tick();
    chk("t1_out", Out, 8'h20);
    chk("t1_busy", Busy, 1);
    chk("t1_count0", Count, 0);
    repeat (3) tick();
    chk("t1_nodone", Done, 0);
    tick();
    chk("t1_done", Done, 1);
    chk("t1_busy_fall", Busy, 0);
    chk("t1_out_idle", Out, 0);
    tick();
    chk("t1_done_pulse", Done, 0);

    // 2: back-to-back codes
    put(3'd0, 1); tick();
    put(3'd7, 1); tick();
    put(3'd2, 1); tick();
    Valid = 1'b0;
    repeat (14) tick();
    chk("t2_ovf", Ovf, 0);
    chk("t2_idle", Busy, 0);
    chk("t2_q", q.size(), 0);

    // 3: fill while paused, overflow
    EN = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      put(3'(i), 1);
      tick();
    end
    chk("t3_ready", Ready, 0);
    chk("t3_count", Count, 4);
    put(3'd5, 0);
    tick();
    Valid = 1'b0;
    chk("t3_ovf", Ovf, 1);
    chk("t3_count_full", Count, 4);
    chk("t3_out_paused", Out, 0);
    EN = 1'b1;
    repeat (20) tick();
    chk("t3_q", q.size(), 0);
    chk("t3_ovf_sticky", Ovf, 1);
    chk("t3_count_end", Count, 0);

    // 4: pause mid-hold
    put(3'd1, 1);
    tick();
    Valid = 1'b0;
    repeat (2) tick();
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_pause_out", Out, 0);
      chk("t4_pause_busy", Busy, 1);
    end
    EN = 1'b1;
    tick();
    chk("t4_resume", Out, 8'h02);
    tick();
    chk("t4_resume2", Out, 8'h02);
    tick();
    chk("t4_done", Done, 1);
    chk("t4_out_end", Out, 0);

    // 5: async reset mid-hold
    put(3'd6, 1); tick();
    put(3'd3, 1); tick();
    put(3'd4, 1); tick();
    Valid = 1'b0;
    chk("t5_out", Out, 8'h40);
    chk("t5_count", Count, 2);
    #2 RST_n = 1'b0;
    #1;
    chk("t5_rst_out", Out, 0);
    chk("t5_rst_count", Count, 0);
    chk("t5_rst_ready", Ready, 1);
    q.delete();
    len = 0;
    #1 RST_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_quiet", Out, 0);
    end

    // 6: HOLD=1 instance
    ENb = 1'b1;
    Validb = 1'b1; Yb = 3'd2; tick();
    chk("t6_out0", Outb, 0);
    Yb = 3'd3; tick();
    chk("t6_out_a", Outb, 8'h04);
    chk("t6_done_a", Doneb, 0);
    Yb = 3'd4; tick();
    Validb = 1'b0;
    chk("t6_out_b", Outb, 8'h08);
    chk("t6_done_b", Doneb, 1);
    tick();
    chk("t6_out_c", Outb, 8'h10);
    chk("t6_done_c", Doneb, 1);
    tick();
    chk("t6_out_d", Outb, 0);
    chk("t6_done_d", Doneb, 1);
    tick();
    chk("t6_done_e", Doneb, 0);
    chk("t6_busy", Busyb, 0);

    chk("end_q", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
